// File: rtl/snapshot_mem_bridge.sv
// Register-bus to wide-memory bridge through a snapshot word.
// Trigger-partition accesses launch one memory read or write.
module snapshot_mem_bridge #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int TRIG_LOW       = 1,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                      clk,
  input  logic                      soft_rst,
  input  logic                      req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  output logic                      ack_vld,
  output logic                      err,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      mem_req_vld,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  input  logic                      mem_ack_vld,
  input  logic                      mem_err,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);
  localparam int BW   = BUS_DATA_WIDTH;
  localparam int PCNT = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int RB   = $clog2(MEM_DATA_WIDTH / 8);
  localparam int WB   = $clog2(BUS_DATA_WIDTH / 8);
  localparam int PW   = (PCNT > 1) ? $clog2(PCNT) : 1;
  localparam int CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] TP = (TRIG_LOW != 0) ? '0 : PW'(PCNT - 1);
  localparam logic [BUS_ADDR_WIDTH-1:0] LMASK =
    BUS_ADDR_WIDTH'((64'd1 << WB) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE, S_SS_ACK, S_ERR, S_ACC_MEM
  } state_t;

  state_t                    r_state, w_next;
  logic [MEM_DATA_WIDTH-1:0] r_ss;
  logic [CW-1:0]             r_cnt;
  logic [PW-1:0]             r_part;
  logic                      r_rd;
  logic                      r_mem_req, r_mem_wr, r_mem_rd;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;

  logic [PW-1:0] w_part;
  logic          w_ill, w_trig, w_acc, w_to, w_mdone;
  logic          w_unused;

  assign w_part   = (PCNT > 1) ? addr[WB +: PW] : '0;
  assign w_ill    = (|(addr & LMASK)) || (wr_en == rd_en);
  assign w_trig   = (w_part == TP);
  assign w_acc    = req_vld && (r_state == S_IDLE);
  assign w_to     = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_mdone  = (r_state == S_ACC_MEM) && (mem_ack_vld || w_to);
  assign w_unused = ^addr;

  assign mem_req_vld = r_mem_req;
  assign mem_wr_en   = r_mem_wr;
  assign mem_rd_en   = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr ? r_ss : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_vld)
          w_next = w_ill ? S_ERR : (w_trig ? S_ACC_MEM : S_SS_ACK);
      S_SS_ACK:  w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      S_ACC_MEM: if (mem_ack_vld || w_to) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Reset suppresses any ack, including one racing a mem ack
  always_comb begin
    ack_vld = 1'b0;
    err     = 1'b0;
    rd_data = '0;
    if (!soft_rst) begin
      unique case (r_state)
        S_SS_ACK: begin
          ack_vld = 1'b1;
          if (r_rd) rd_data = r_ss[r_part*BW +: BW];
        end
        S_ERR: begin
          ack_vld = 1'b1;
          err     = 1'b1;
        end
        S_ACC_MEM: begin
          if (mem_ack_vld) begin
            ack_vld = 1'b1;
            err     = mem_err;
            if (r_mem_rd) rd_data = mem_rd_data[TP*BW +: BW];
          end else if (w_to) begin
            ack_vld = 1'b1;
            err     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      r_state    <= S_IDLE;
      r_ss       <= '0;
      r_cnt      <= '0;
      r_part     <= '0;
      r_rd       <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_cnt <= '0;
      else if (r_state == S_ACC_MEM)
        r_cnt <= r_cnt + CW'(1);
      if (w_acc && !w_ill) begin
        r_part <= w_part;
        r_rd   <= rd_en;
        if (wr_en) r_ss[w_part*BW +: BW] <= wr_data;
        if (w_trig) begin
          r_mem_req  <= 1'b1;
          r_mem_wr   <= wr_en;
          r_mem_rd   <= rd_en;
          r_mem_addr <= addr[RB +: MEM_ADDR_WIDTH];
        end
      end
      if (w_mdone) begin
        r_mem_req  <= 1'b0;
        r_mem_wr   <= 1'b0;
        r_mem_rd   <= 1'b0;
        r_mem_addr <= '0;
        if (mem_ack_vld && r_mem_rd) r_ss <= mem_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_snapshot_mem_bridge.sv
// Directed bench for snapshot_mem_bridge: default build plus
// a 128-bit, high-trigger build.
module tb_snapshot_mem_bridge;
  logic        clk = 1'b0;
  logic        soft_rst;
  logic        req_vld, wr_en, rd_en;
  logic [63:0] addr;
  logic [31:0] wr_data, rd_data;
  logic        ack_vld, err;
  logic        mem_req_vld, mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data, mem_rd_data;
  logic        mem_ack_vld, mem_err;

  logic         b_req_vld, b_wr_en, b_rd_en;
  logic [63:0]  b_addr;
  logic [31:0]  b_wr_data, b_rd_data;
  logic         b_ack_vld, b_err;
  logic         b_mem_req_vld, b_mem_wr_en, b_mem_rd_en;
  logic [31:0]  b_mem_addr;
  logic [127:0] b_mem_wr_data, b_mem_rd_data;
  logic         b_mem_ack_vld, b_mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snapshot_mem_bridge u_dut (
    .clk(clk), .soft_rst(soft_rst),
    .req_vld(req_vld), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .ack_vld(ack_vld), .err(err), .rd_data(rd_data),
    .mem_req_vld(mem_req_vld), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_ack_vld(mem_ack_vld),
    .mem_err(mem_err), .mem_rd_data(mem_rd_data)
  );

  snapshot_mem_bridge #(
    .MEM_DATA_WIDTH(128), .TRIG_LOW(0)
  ) u_dut_b (
    .clk(clk), .soft_rst(soft_rst),
    .req_vld(b_req_vld), .addr(b_addr),
    .wr_en(b_wr_en), .rd_en(b_rd_en), .wr_data(b_wr_data),
    .ack_vld(b_ack_vld), .err(b_err), .rd_data(b_rd_data),
    .mem_req_vld(b_mem_req_vld), .mem_addr(b_mem_addr),
    .mem_wr_en(b_mem_wr_en), .mem_rd_en(b_mem_rd_en),
    .mem_wr_data(b_mem_wr_data), .mem_ack_vld(b_mem_ack_vld),
    .mem_err(b_mem_err), .mem_rd_data(b_mem_rd_data)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the first cycle after accept
  task automatic acc(input logic w, input logic r,
                     input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic bacc(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    b_req_vld = 1'b1; b_wr_en = 1'b1; b_addr = a; b_wr_data = d;
    @(negedge clk);
    b_req_vld = 1'b0; b_wr_en = 1'b0;
  endtask

  initial begin
    int n;
    soft_rst = 1'b1;
    req_vld = 0; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0;
    mem_ack_vld = 0; mem_err = 0; mem_rd_data = '0;
    b_req_vld = 0; b_wr_en = 0; b_rd_en = 0; b_addr = '0;
    b_wr_data = '0; b_mem_ack_vld = 0; b_mem_err = 0;
    b_mem_rd_data = '0;
    repeat (2) @(negedge clk);
    soft_rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack_vld, 0);
    chk("rst_req", mem_req_vld, 0);
    chk("rst_wdat", mem_wr_data, 0);
    chk("rst_rdat", rd_data, 0);

    // T1
    acc(1, 0, 64'h1004, 32'hAAAA5555);
    chk("t1_ss_ack", ack_vld, 1);
    chk("t1_ss_err", err, 0);
    chk("t1_ss_noreq", mem_req_vld, 0);
    acc(1, 0, 64'h1000, 32'h11223344);
    chk("t1_noack", ack_vld, 0);
    chk("t1_req", mem_req_vld, 1);
    chk("t1_wen", mem_wr_en, 1);
    chk("t1_ren", mem_rd_en, 0);
    chk("t1_addr", mem_addr, 32'h200);
    chk("t1_wdat", mem_wr_data, 64'hAAAA5555_11223344);
    repeat (2) @(negedge clk);
    chk("t1_hold", mem_req_vld, 1);
    chk("t1_hold_ack", ack_vld, 0);
    mem_ack_vld = 1;
    #1;
    chk("t1_mack", ack_vld, 1);
    chk("t1_merr", err, 0);
    chk("t1_mrdat", rd_data, 0);
    @(negedge clk);
    mem_ack_vld = 0;
    chk("t1_drop", mem_req_vld, 0);
    chk("t1_wdat0", mem_wr_data, 0);
    chk("t1_pulse", ack_vld, 0);

    // T2
    acc(0, 1, 64'h2000, 32'h0);
    chk("t2_ren", mem_rd_en, 1);
    chk("t2_addr", mem_addr, 32'h400);
    chk("t2_wdat0", mem_wr_data, 0);
    mem_rd_data = 64'hDEADBEEF_CAFEF00D;
    mem_ack_vld = 1;
    #1;
    chk("t2_ack", ack_vld, 1);
    chk("t2_rdat", rd_data, 32'hCAFEF00D);
    @(negedge clk);
    mem_ack_vld = 0;
    mem_rd_data = '0;
    acc(0, 1, 64'h2004, 32'h0);
    chk("t2_ss_ack", ack_vld, 1);
    chk("t2_ss_rdat", rd_data, 32'hDEADBEEF);
    chk("t2_ss_noreq", mem_req_vld, 0);
    @(negedge clk);
    chk("t2_pulse", ack_vld, 0);

    // T3
    acc(0, 1, 64'h3000, 32'h0);
    n = 1;
    while (!ack_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t3_cycles", n, 255);
    chk("t3_err", err, 1);
    chk("t3_rdat", rd_data, 0);
    @(negedge clk);
    chk("t3_drop", mem_req_vld, 0);
    acc(0, 1, 64'h2004, 32'h0);
    chk("t3_ss_kept", rd_data, 32'hDEADBEEF);

    // T4
    acc(1, 0, 64'h2006, 32'h12345678);
    chk("t4_mis_ack", ack_vld, 1);
    chk("t4_mis_err", err, 1);
    chk("t4_mis_noreq", mem_req_vld, 0);
    acc(1, 1, 64'h2004, 32'h12345678);
    chk("t4_both_err", err, 1);
    chk("t4_both_rdat", rd_data, 0);
    acc(0, 0, 64'h2004, 32'h0);
    chk("t4_none_err", err, 1);
    acc(0, 1, 64'h2004, 32'h0);
    chk("t4_ss_kept", rd_data, 32'hDEADBEEF);
    chk("t4_ok_err", err, 0);

    // mem_err on a read still loads the snapshot
    acc(0, 1, 64'h2000, 32'h0);
    mem_rd_data = 64'h01234567_89ABCDEF;
    mem_err = 1;
    mem_ack_vld = 1;
    #1;
    chk("me_err", err, 1);
    chk("me_rdat", rd_data, 32'h89ABCDEF);
    @(negedge clk);
    mem_ack_vld = 0; mem_err = 0; mem_rd_data = '0;
    acc(0, 1, 64'h2004, 32'h0);
    chk("me_loaded", rd_data, 32'h01234567);

    // T5
    acc(0, 1, 64'h3000, 32'h0);
    chk("t5_req", mem_req_vld, 1);
    soft_rst = 1;
    mem_ack_vld = 1;
    #1;
    chk("t5_noack", ack_vld, 0);
    @(negedge clk);
    soft_rst = 0;
    mem_ack_vld = 0;
    chk("t5_drop", mem_req_vld, 0);
    chk("t5_noack2", ack_vld, 0);
    acc(0, 1, 64'h2004, 32'h0);
    chk("t5_ss_clr", rd_data, 0);
    acc(1, 0, 64'h2000, 32'h55);
    chk("t5_wen", mem_wr_en, 1);
    chk("t5_wdat", mem_wr_data, 64'h55);
    mem_ack_vld = 1;
    #1;
    chk("t5_ack", ack_vld, 1);
    @(negedge clk);
    mem_ack_vld = 0;

    // T6
    bacc(64'h0, 32'h11111111);
    chk("t6_w0_ack", b_ack_vld, 1);
    chk("t6_w0_noreq", b_mem_req_vld, 0);
    bacc(64'h4, 32'h22222222);
    chk("t6_w1_noreq", b_mem_req_vld, 0);
    bacc(64'h8, 32'h33333333);
    chk("t6_w2_ack", b_ack_vld, 1);
    chk("t6_w2_noreq", b_mem_req_vld, 0);
    bacc(64'hC, 32'h44444444);
    chk("t6_noack", b_ack_vld, 0);
    chk("t6_wen", b_mem_wr_en, 1);
    chk("t6_addr", b_mem_addr, 0);
    chk("t6_wdat", b_mem_wr_data,
        128'h44444444_33333333_22222222_11111111);
    b_mem_ack_vld = 1;
    #1;
    chk("t6_ack", b_ack_vld, 1);
    @(negedge clk);
    b_mem_ack_vld = 0;
    chk("t6_drop", b_mem_req_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
